// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package mdu_pkg;

   // MDUOp encodings; 5..7 are treated as NONE
   typedef enum logic [2:0] {
      MDU_NONE = 3'd0,
      MDU_MULT = 3'd1,
      MDU_DIV  = 3'd2,
      MDU_MTHI = 3'd3,
      MDU_MTLO = 3'd4
   } mdu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_t;

   // LO result for a divide by zero
   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; the top latches its result at launch.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [31:0] RData1,
   input  logic [31:0] RData2,
   input  logic        CalcuSigned,
   input  logic        is_div,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] a64, b64, prod;
   logic        neg_a, neg_b, div0, ovf;
   logic [31:0] ua, ub, ub_safe, uq, ur, q, r;

   // Extend operands to 64 bits so one unsigned multiplier covers both signednesses,
   // and divide on magnitudes, restoring signs afterwards (truncate toward zero).
   always_comb begin
      a64     = CalcuSigned ? {{32{RData1[31]}}, RData1} : {32'b0, RData1};
      b64     = CalcuSigned ? {{32{RData2[31]}}, RData2} : {32'b0, RData2};
      prod    = a64 * b64;

      neg_a   = CalcuSigned & RData1[31];
      neg_b   = CalcuSigned & RData2[31];
      ua      = neg_a ? -RData1 : RData1;
      ub      = neg_b ? -RData2 : RData2;
      div0    = (RData2 == 32'd0);
      ovf     = CalcuSigned && (RData1 == 32'h8000_0000) && (RData2 == 32'hFFFF_FFFF);
      // keep the divider away from a zero divisor; that case is overridden below
      ub_safe = div0 ? 32'd1 : ub;
      uq      = ua / ub_safe;
      ur      = ua % ub_safe;
      q       = (neg_a ^ neg_b) ? -uq : uq;
      r       = neg_a ? -ur : ur;

      res_hi  = prod[63:32];
      res_lo  = prod[31:0];
      if (is_div) begin
         if (div0) begin
            res_hi = RData1;
            res_lo = DIV0_LO;
         end else if (ovf) begin
            res_hi = 32'd0;
            res_lo = 32'h8000_0000;
         end else begin
            res_hi = r;
            res_lo = q;
         end
      end
   end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div, single-cycle mthi/mtlo, HI/LO holder.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDUOp,
   input  logic        CalcuSigned,
   input  logic [31:0] RData1,
   input  logic [31:0] RData2,
   input  logic        ReadHi,
   output logic        Busy,
   output logic [31:0] Out
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   mdu_state_t  state, state_nx;
   logic [3:0]  cnt;
   logic [31:0] hi, lo, phi, plo;
   logic [31:0] res_hi, res_lo;
   logic        is_div, launch, commit, wr_hi, wr_lo;

   assign is_div = (MDUOp == MDU_DIV);

   mdu_arith u_arith (
      .RData1      (RData1),
      .RData2      (RData2),
      .CalcuSigned (CalcuSigned),
      .is_div      (is_div),
      .res_hi      (res_hi),
      .res_lo      (res_lo)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and per-edge actions; Start is only honoured in IDLE
   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      commit   = 1'b0;
      wr_hi    = 1'b0;
      wr_lo    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               case (MDUOp)
                  MDU_MULT, MDU_DIV: begin
                     launch   = 1'b1;
                     state_nx = RUN;
                  end
                  MDU_MTHI: wr_hi = 1'b1;
                  MDU_MTLO: wr_lo = 1'b1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt == 4'd0) begin
               commit   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Result is computed at launch and held in pHI/pLO until the countdown expires
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= 4'd0;
         phi  <= 32'd0;
         plo  <= 32'd0;
         hi   <= 32'd0;
         lo   <= 32'd0;
         Busy <= 1'b0;
      end else begin
         if (launch) begin
            phi  <= res_hi;
            plo  <= res_lo;
            cnt  <= is_div ? DIV_LOAD : MULT_LOAD;
            Busy <= 1'b1;
         end else if (commit) begin
            hi   <= phi;
            lo   <= plo;
            Busy <= 1'b0;
         end else if (state == RUN) begin
            cnt  <= cnt - 4'd1;
         end
         if (wr_hi) hi <= RData1;
         if (wr_lo) lo <= RData1;
      end
   end

   // Committed registers only; pending results stay hidden
   assign Out = ReadHi ? hi : lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO, monitor compares on output events.
module tb_mdu_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [2:0]  MDUOp;
   logic        CalcuSigned;
   logic [31:0] RData1, RData2;
   logic        ReadHi;
   logic        Busy;
   logic [31:0] Out;

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .CalcuSigned(CalcuSigned),
      .RData1(RData1), .RData2(RData2), .ReadHi(ReadHi), .Busy(Busy), .Out(Out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          lat;   // expected busy cycles (0 = probe while idle)
      logic [31:0] hi;
      logic [31:0] lo;
   } item_t;

   item_t       sb[$];
   int          nvec = 0;
   int          nmis = 0;
   int          probe_req = 0;
   int          probe_ack = 0;
   logic [31:0] m_hi = 0, m_lo = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: an output event is either Busy falling (result committed) or a stimulus probe
   initial begin : monitor
      int   run;
      logic prev;
      logic fall;
      item_t it;
      logic [31:0] h, l;
      run    = 0;
      prev   = 1'b0;
      ReadHi = 1'b0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            run  = 0;
            prev = 1'b0;
         end else begin
            if (Busy) run++;
            fall = prev && !Busy;
            if (fall || probe_req != probe_ack) begin
               if (!fall) probe_ack++;
               ReadHi = 1'b1; #1 h = Out;
               ReadHi = 1'b0; #1 l = Out;
               if (sb.size() == 0) begin
                  nvec++; nmis++;
                  $display("FAIL unexpected_event: got event with empty scoreboard, expected none");
               end else begin
                  it = sb.pop_front();
                  if (fall) chk("busy_cycles", 32'(run), 32'(it.lat));
                  else      chk("busy_idle", {31'b0, Busy}, 32'd0);
                  chk("hi", h, it.hi);
                  chk("lo", l, it.lo);
               end
               run = 0;
            end
            prev = Busy;
         end
      end
   end

   // Reference model: plain arithmetic on the architectural rules
   task automatic model(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      longint p;
      int     sa, sb2;
      lat = 0;
      case (op)
         3'd1: begin
            if (sg) p = longint'($signed(a)) * longint'($signed(b));
            else    p = longint'({32'b0, a}) * longint'({32'b0, b});
            m_hi = p[63:32];
            m_lo = p[31:0];
            lat  = MC;
         end
         3'd2: begin
            if (b == 0) begin
               m_hi = a; m_lo = 32'hFFFF_FFFF;
            end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               m_hi = 0; m_lo = 32'h8000_0000;
            end else if (sg) begin
               sa = $signed(a); sb2 = $signed(b);
               m_lo = sa / sb2;
               m_hi = sa % sb2;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
            lat = DC;
         end
         3'd3: m_hi = a;
         3'd4: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic probe();
      item_t it;
      it.lat = 0; it.hi = m_hi; it.lo = m_lo;
      sb.push_back(it);
      probe_req++;
   endtask

   task automatic pulse(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      Start = 1'b1; MDUOp = op; CalcuSigned = sg; RData1 = a; RData2 = b;
      @(posedge clk); #1;
      Start = 1'b0; MDUOp = 3'd0; RData1 = $urandom; RData2 = $urandom;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!Busy) begin done = 1; break; end
      end
      if (!done) begin
         nvec++; nmis++;
         $display("FAIL busy_timeout: Busy still 1 after 40 cycles, expected 0");
      end
   endtask

   // Full operation: model, push, launch, and for idle ops check both before and after the edge
   task automatic issue(input logic [2:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
      int    lat;
      item_t it;
      if (op == 3'd1 || op == 3'd2) begin
         model(op, sg, a, b, lat);
         it.lat = lat; it.hi = m_hi; it.lo = m_lo;
         sb.push_back(it);
         pulse(op, sg, a, b);
         wait_idle();
         @(negedge clk);
      end else begin
         @(posedge clk); #1;
         Start = 1'b1; MDUOp = op; CalcuSigned = sg; RData1 = a; RData2 = b;
         probe();                 // old value still visible while Start is high
         @(posedge clk); #1;
         Start = 1'b0; MDUOp = 3'd0;
         model(op, sg, a, b, lat);
         probe();                 // new value visible the cycle after the write edge
         @(negedge clk);
      end
   endtask

   initial begin : stim
      int lat;
      logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
      reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; CalcuSigned = 1'b0; RData1 = 0; RData2 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      probe();                                            // reset state
      @(posedge clk); #1;

      issue(3'd1, 1'b1, -32'sd3, 32'd7);                  // FFFF_FFFF / FFFF_FFEB
      issue(3'd1, 1'b0, 32'hFFFF_FFFF, 32'd2);            // 1 / FFFF_FFFE
      issue(3'd2, 1'b1, -32'sd7, 32'd2);                  // LO=-3, HI=-1
      issue(3'd2, 1'b0, 32'd7, 32'd0);                    // divide by zero
      issue(3'd2, 1'b1, 32'd9, 32'd0);                    // signed divide by zero
      issue(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);    // overflow
      issue(3'd3, 1'b0, 32'h1234_5678, 32'd0);            // mthi
      issue(3'd4, 1'b0, 32'hCAFE_F00D, 32'd0);            // mtlo

      // Start(mtlo) while busy is ignored; latency and result untouched
      model(3'd1, 1'b1, 32'd100, -32'sd5, lat);
      begin
         item_t it;
         it.lat = lat; it.hi = m_hi; it.lo = m_lo;
         sb.push_back(it);
      end
      pulse(3'd1, 1'b1, 32'd100, -32'sd5);
      pulse(3'd4, 1'b0, 32'hDEAD_BEEF, 32'd0);
      wait_idle();
      @(posedge clk); #1;
      probe();

      // NONE and reserved opcodes are no-ops
      for (int k = 5; k < 8; k++) pulse(3'(k), 1'b0, $urandom, $urandom);
      pulse(3'd0, 1'b1, $urandom, $urandom);
      probe();
      @(posedge clk); #1;

      // Reset in the middle of a mult aborts it with no late write
      pulse(3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_hi = 0; m_lo = 0;
      probe();
      repeat (12) @(posedge clk);
      #1 probe();
      @(posedge clk); #1;

      // Randomized mix
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a, b;
         logic [2:0]  op;
         op = ops[$urandom_range(0, 4)];
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         if (op == 3'd0) begin
            pulse(3'(5 + $urandom_range(0, 2)), 1'($urandom), a, b);
            probe();
            @(posedge clk); #1;
         end else begin
            issue(op, 1'($urandom), a, b);
         end
      end

      repeat (4) @(posedge clk);
      nvec++;
      if (sb.size() != 0) begin
         nmis++;
         $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
